// File: rtl/rf_wport_sched.sv
// rf_wport_sched: write-port scheduler for the MIPS register file.
//
// The single register-file write port is shared by the in-order WB stage and
// the multi-cycle MDU (mult/div) result path. WB always wins the port. A
// destination scoreboard tracks MDU results that are still outstanding, and ID
// is stalled on RAW/WAW hazards against them. A starvation FSM asks the
// pipeline for a WB bubble when an MDU result has waited too long.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   wb_wr/wb_addr/wb_data WB stage write request
//   mdu_req/addr/data     MDU result, held stable until mdu_ack
//   mdu_ack               MDU result written this cycle
//   iss_valid/iss_addr    ID issuing an MDU op and its destination
//   id_rs/id_rt           ID source registers
//   stall_id              hold IF/ID, bubble into EX
//   hold_pipe             request a WB bubble at the next edge
//   wr/addr3/data3        register-file write port
//   pend_cnt              number of tracked pending MDU destinations
module rf_wport_sched #(
  parameter int MAX_PEND   = 2,
  parameter int STARVE_LIM = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_wr,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          mdu_req,
  input  logic [4:0]    mdu_addr,
  input  logic [31:0]   mdu_data,
  output logic          mdu_ack,
  input  logic          iss_valid,
  input  logic [4:0]    iss_addr,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  output logic          stall_id,
  output logic          hold_pipe,
  output logic          wr,
  output logic [4:0]    addr3,
  output logic [31:0]   data3,
  output logic [CW-1:0] pend_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_GRANT} state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  // Bit 0 is never set, so $0 indexes read as not busy.
  logic [31:0]   busy_q, busy_nxt;
  logic [CW-1:0] pend_q, pend_nxt;
  logic          pend_full;
  logic          sb_set, sb_clr;

  // Write-port mux: WB has absolute priority over the MDU.
  always_comb begin
    wr      = 1'b0;
    addr3   = 5'd0;
    data3   = 32'd0;
    mdu_ack = 1'b0;
    if (wb_wr) begin
      wr    = 1'b1;
      addr3 = wb_addr;
      data3 = wb_data;
    end else if (mdu_req) begin
      wr      = 1'b1;
      addr3   = mdu_addr;
      data3   = mdu_data;
      mdu_ack = 1'b1;
    end
  end

  // Hazard detection uses the pre-edge busy state; the register file forwards
  // the ack write itself, so releasing the stall one cycle later is correct.
  assign pend_full = (pend_q == CW'(MAX_PEND));
  assign stall_id  = ((id_rs != 5'd0) && busy_q[id_rs])
                   | ((id_rt != 5'd0) && busy_q[id_rt])
                   | (iss_valid && (((iss_addr != 5'd0) && busy_q[iss_addr]) | pend_full));

  // Only a busy destination is cleared, so a stray ack cannot underflow the
  // count. A set can never hit a busy register (that stalls), so set and
  // clear in the same cycle always target different registers.
  assign sb_set = iss_valid && !stall_id && (iss_addr != 5'd0);
  assign sb_clr = mdu_ack && (mdu_addr != 5'd0) && busy_q[mdu_addr];

  always_comb begin
    busy_nxt = busy_q;
    if (sb_clr) busy_nxt[mdu_addr] = 1'b0;
    if (sb_set) busy_nxt[iss_addr] = 1'b1;
    case ({sb_set, sb_clr})
      2'b10:   pend_nxt = pend_q + CW'(1);
      2'b01:   pend_nxt = pend_q - CW'(1);
      default: pend_nxt = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      pend_q <= pend_nxt;
    end
  end

  assign pend_cnt = pend_q;

  // Starvation FSM. An ack in any state ends the episode. A dropped request
  // (only possible after a protocol violation) also returns to IDLE.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (mdu_ack) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_req && wb_wr) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
        S_WAIT: begin
          if (!mdu_req) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (cnt_q == CW'(STARVE_LIM)) begin
            state_nxt = S_HOLD;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          state_nxt = mdu_req ? S_GRANT : S_IDLE;
        end
        S_GRANT: begin
          // WB took the port despite the bubble request: ask again.
          state_nxt = mdu_req ? S_HOLD : S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign hold_pipe = (state_q == S_HOLD);

endmodule
